// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  localparam int unsigned DIV_WIDTH = 32;

  localparam logic [DIV_WIDTH-1:0] DIV0_QUOTIENT = {DIV_WIDTH{1'b1}};

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             quo_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit,
  output logic             borrow
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;

  always_comb begin
    shifted  = {rem, quo_msb};
    // One guard bit past WIDTH+1 so the top bit is the borrow out.
    trial    = {1'b0, shifted} - {2'b00, divisor};
    borrow   = trial[WIDTH+1];
    q_bit    = ~borrow;
    rem_next = borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
  end

endmodule

// File: rtl/div_32_seq.sv
// Sequential 32-bit restoring divider, lo = quotient, hi = remainder, one quotient bit per clock.
// Optional two's-complement mode behind `DIV_SIGNED_EN (adds the signed_op input).
module div_32_seq
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef DIV_SIGNED_EN
  input  logic             signed_op,
`endif
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;

  logic [WIDTH-1:0] step_rem;
  logic             step_qbit;
  logic             step_borrow;
  logic             unused_borrow;
  logic [WIDTH-1:0] quo_next;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] fin_hi;
  logic [WIDTH-1:0] fin_lo;

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem     (rem_q),
    .quo_msb (quo_q[WIDTH-1]),
    .divisor (dvs_q),
    .rem_next(step_rem),
    .q_bit   (step_qbit),
    .borrow  (step_borrow)
  );

  assign unused_borrow = step_borrow;
  assign quo_next      = {quo_q[WIDTH-2:0], step_qbit};

`ifdef DIV_SIGNED_EN
  logic neg_a;
  logic neg_b;
  logic neg_quo_q;
  logic neg_rem_q;

  always_comb begin
    neg_a  = signed_op & dividend[WIDTH-1];
    neg_b  = signed_op & divisor[WIDTH-1];
    mag_a  = neg_a ? (~dividend + 1'b1) : dividend;
    mag_b  = neg_b ? (~divisor + 1'b1) : divisor;
    // Truncation toward zero: quotient negated on sign mismatch, remainder follows dividend.
    fin_lo = neg_quo_q ? (~quo_next + 1'b1) : quo_next;
    fin_hi = neg_rem_q ? (~step_rem + 1'b1) : step_rem;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else if (state == IDLE && start) begin
      neg_quo_q <= neg_a ^ neg_b;
      neg_rem_q <= neg_a;
    end
  end
`else
  always_comb begin
    mag_a  = dividend;
    mag_b  = divisor;
    fin_lo = quo_next;
    fin_hi = step_rem;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      hi          <= '0;
      lo          <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            div_by_zero <= 1'b0;
            dvs_q       <= mag_b;
            if (divisor == '0) begin
              // Results are staged here and published from FIN.
              rem_q <= dividend;
              quo_q <= WIDTH'(DIV0_QUOTIENT);
              state <= FIN;
            end else begin
              rem_q <= '0;
              quo_q <= mag_a;
              cnt   <= '0;
              busy  <= 1'b1;
              state <= RUN;
            end
          end
        end
        RUN: begin
          rem_q <= step_rem;
          quo_q <= quo_next;
          cnt   <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            hi    <= fin_hi;
            lo    <= fin_lo;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= FIN;
          end
        end
        FIN: begin
          if (!done) begin
            // Only the divide-by-zero path arrives here with done still low.
            hi          <= rem_q;
            lo          <= quo_q;
            div_by_zero <= 1'b1;
            done        <= 1'b1;
          end else begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_32_seq.sv
// Scoreboard bench for div_32_seq: stimulus pushes expected results, a monitor checks on done.
module tb_div_32_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div_by_zero;
`ifdef DIV_SIGNED_EN
  logic        signed_op;
`endif

  div_32_seq dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
`ifdef DIV_SIGNED_EN
    .signed_op  (signed_op),
`endif
    .hi         (hi),
    .lo         (lo),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   fails    = 0;
  int   cyc      = 0;
  int   busy_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && busy) busy_cnt++;
    if (!rst && done) begin
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_done: done high at cycle %0d with nothing outstanding", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("lo", lo, e.lo);
        check("hi", hi, e.hi);
        check("div_by_zero", {31'b0, div_by_zero}, {31'b0, e.dz});
        check("done_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      checks++;
      fails++;
      $display("FAIL timeout: %0d results still outstanding", sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] q,
                       input logic [31:0] r, input logic dz, input logic sop);
    exp_t e;
    @(negedge clk);
    busy_cnt = 0;
    start    = 1'b1;
    dividend = a;
    divisor  = b;
`ifdef DIV_SIGNED_EN
    signed_op = sop;
`else
    if (sop) $display("note: signed vector issued without signed support");
`endif
    @(posedge clk);
    #1;
    start = 1'b0;
    e.hi  = r;
    e.lo  = q;
    e.dz  = dz;
    e.cyc = cyc + (dz ? 1 : 32);
    sb.push_back(e);
  endtask

  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic [31:0] q,
                         input logic [31:0] r, input logic dz, input logic sop);
    issue(a, b, q, r, dz, sop);
    drain();
  endtask

  initial begin
    exp_t e;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
`ifdef DIV_SIGNED_EN
    signed_op = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_dz", {31'b0, div_by_zero}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_div(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0);
    check("busy_cycles", busy_cnt, 32'd32);

    run_div(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);
    run_div(32'd5, 32'd9, 32'd0, 32'd5, 1'b0, 1'b0);

    run_div(32'd1234, 32'd0, 32'hFFFF_FFFF, 32'd1234, 1'b1, 1'b0);
    check("dz_held", {31'b0, div_by_zero}, 32'd1);
    check("dz_busy_never", busy_cnt, 32'd0);

    // Start re-pulsed mid-run must be ignored; also clears the held div_by_zero.
    issue(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    start    = 1'b1;
    dividend = 32'd1000;
    divisor  = 32'd3;
    @(negedge clk);
    start = 1'b0;
    drain();

    // Start held high: second operation accepted on the first IDLE edge.
    @(negedge clk);
    start    = 1'b1;
    dividend = 32'd200;
    divisor  = 32'd9;
    @(posedge clk);
    #1;
    dividend = 32'd81;
    divisor  = 32'd4;
    e.hi = 32'd2;  e.lo = 32'd22; e.dz = 1'b0; e.cyc = cyc + 32;
    sb.push_back(e);
    e.hi = 32'd1;  e.lo = 32'd20; e.dz = 1'b0; e.cyc = cyc + 66;
    sb.push_back(e);
    for (int i = 0; i < 200 && sb.size() > 1; i++) @(negedge clk);
    for (int i = 0; i < 200 && sb.size() > 0; i++) @(negedge clk);
    start = 1'b0;
    drain();

    // Asynchronous reset mid-run aborts without a done pulse.
    @(negedge clk);
    start    = 1'b1;
    dividend = 32'd100;
    divisor  = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_hi", hi, 32'd0);
    check("arst_lo", lo, 32'd0);
    check("arst_busy", {31'b0, busy}, 32'd0);
    check("arst_done", {31'b0, done}, 32'd0);
    check("arst_dz", {31'b0, div_by_zero}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    run_div(32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 1'b0);

`ifdef DIV_SIGNED_EN
    run_div(32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b1);
    run_div(32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 1'b1);
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 1'b1);
    run_div(32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1, 1'b1);
`endif

    check("sb_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
